// File: rtl/est_sync_buffer_fifo.sv
// Elastic token FIFO between two 4-phase return-to-zero channels.
// The upstream side captures a token (nonzero tag in the two MSBs) into a small
// memory and handshakes it with ack. The downstream side presents the oldest
// token, waits for ack_next, then returns to a spacer before presenting the next.
module est_sync_buffer_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_next,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two, so pointers of AW bits wrap at DEPTH on their own.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] IN_IDLE  = 1'b0;
  localparam logic [0:0] IN_ACK   = 1'b1;
  localparam logic [0:0] O_SPACER = 1'b0;
  localparam logic [0:0] O_TOKEN  = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [0:0]       in_state;
  logic [0:0]       out_state;
  logic             det;
  logic             write;
  logic             pop;
  logic             load;
  logic [CW-1:0]    count_next;

  // Any nonzero tag marks a valid token; tag 00 is a spacer.
  assign det = data_in[WIDTH-1] | data_in[WIDTH-2];

  // full is the registered flag, so a pop at the same edge does not unblock a write.
  assign write = (in_state == IN_IDLE) && det && !full;
  assign pop   = (out_state == O_TOKEN) && ack_next;
  // A stale ack_next still high from the previous token holds off the next one.
  assign load  = (out_state == O_SPACER) && !empty && !ack_next;

  assign ack = (in_state == IN_ACK);

  // Token storage; no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wptr] <= data_in;
    end
  end

  // Upstream handshake: capture a token, then wait for its return to spacer.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state <= IN_IDLE;
      wptr     <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (write) begin
            wptr     <= wptr + 1'b1;
            in_state <= IN_ACK;
          end
        end
        default: begin
          if (!det) begin
            in_state <= IN_IDLE;
          end
        end
      endcase
    end
  end

  // Downstream handshake: present the head token, pop it on ack_next, then spacer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= O_SPACER;
      rptr      <= '0;
      data_out  <= '0;
    end else begin
      case (out_state)
        O_SPACER: begin
          if (load) begin
            data_out  <= mem[rptr];
            out_state <= O_TOKEN;
          end
        end
        default: begin
          if (pop) begin
            data_out  <= '0;
            rptr      <= rptr + 1'b1;
            out_state <= O_SPACER;
          end
        end
      endcase
    end
  end

  // Occupancy after this edge; a write and a pop together cancel out.
  always_comb begin
    count_next = count;
    case ({write, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Registered occupancy and flags derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_est_sync_buffer_fifo.sv
// Bench for est_sync_buffer_fifo: a queue-based model of the two handshakes is
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_est_sync_buffer_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             ack_next;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  est_sync_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ack      (ack),
    .data_out (data_out),
    .ack_next (ack_next),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int max_count = 0;

  // Model state: stored tokens (head first), upstream ack, head presented flag.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] popped[$];
  logic             m_ack  = 1'b0;
  logic             m_pres = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] popped_at(input int i);
    if (i < popped.size()) return popped[i];
    return 'x;
  endfunction

  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (ack !== val && n < 50) begin
      tick();
      n++;
    end
    if (ack !== val) check({name, " ack timeout"}, 32'(ack), 32'(val));
  endtask

  task automatic send_token(input logic [WIDTH-1:0] v);
    data_in = v;
    wait_ack(1'b1, "send");
    data_in = '0;
    wait_ack(1'b0, "send");
  endtask

  // 4-phase downstream: ack a presented token, release ack on the spacer.
  task automatic responder(input int target, input bit rnd);
    int n = 0;
    while (popped.size() < target && n < 400) begin
      tick();
      n++;
      if (!rnd || $urandom_range(0, 2) != 0) begin
        if (data_out != '0 && !ack_next) ack_next = 1'b1;
        else if (data_out == '0 && ack_next) ack_next = 1'b0;
      end
    end
    if (popped.size() < target) check("drain timeout", popped.size(), target);
  endtask

  initial begin
    rst      = 1'b1;
    data_in  = '0;
    ack_next = 1'b0;

    // Model: one update per rising edge from the inputs seen at that edge.
    fork
      forever begin
        logic det, acc, pop, load;
        @(posedge clk);
        if (rst) begin
          q.delete();
          m_ack  = 1'b0;
          m_pres = 1'b0;
        end else begin
          det  = data_in[WIDTH-1] | data_in[WIDTH-2];
          acc  = !m_ack && det && (q.size() < DEPTH);
          pop  = m_pres && ack_next;
          load = !m_pres && (q.size() > 0) && !ack_next;
          if (pop) begin
            popped.push_back(q[0]);
            void'(q.pop_front());
            m_pres = 1'b0;
          end
          if (load) m_pres = 1'b1;
          if (acc) q.push_back(data_in);
          if (acc) m_ack = 1'b1;
          else if (m_ack && !det) m_ack = 1'b0;
        end
      end
    join_none

    repeat (2) tick();
    check("reset ack", 32'(ack), 0);
    check("reset data_out", 32'(data_out), 0);
    check("reset count", 32'(count), 0);
    check("reset full", 32'(full), 0);
    check("reset empty", 32'(empty), 1);

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        if (int'(count) > max_count) max_count = int'(count);
        check("cyc ack", 32'(ack), 32'(m_ack));
        check("cyc data_out", 32'(data_out), m_pres ? 32'(q[0]) : 32'h0);
        check("cyc count", 32'(count), q.size());
        check("cyc full", 32'(full), 32'(q.size() == DEPTH));
        check("cyc empty", 32'(empty), 32'(q.size() == 0));
      end
    join_none

    // Single token latency.
    rst     = 1'b0;
    data_in = 16'h4A5C;
    tick();
    check("single ack e0", 32'(ack), 1);
    check("single count e0", 32'(count), 1);
    check("single data_out e0", 32'(data_out), 0);
    data_in = '0;
    tick();
    check("single data_out e1", 32'(data_out), 32'h4A5C);
    ack_next = 1'b1;
    tick();
    check("single pop data_out", 32'(data_out), 0);
    check("single pop count", 32'(count), 0);

    // Fill to full with downstream stalled.
    popped.delete();
    for (int i = 1; i <= 4; i++) send_token(16'h8000 + 16'(i));
    check("fill count", 32'(count), 4);
    check("fill full", 32'(full), 1);
    data_in = 16'h8005;
    repeat (6) tick();
    check("backpressure ack", 32'(ack), 0);
    check("backpressure count", 32'(count), 4);
    fork
      send_token(16'h8005);
      responder(5, 1'b0);
    join
    for (int i = 0; i < 5; i++) check("fill order", 32'(popped_at(i)), 32'h8001 + i);

    // Wrap-around with a randomised legal downstream.
    popped.delete();
    max_count = 0;
    fork
      for (int i = 0; i < 10; i++) send_token(16'hC000 + 16'(i));
      responder(10, 1'b1);
    join
    for (int i = 0; i < 10; i++) check("wrap order", 32'(popped_at(i)), 32'hC000 + i);
    check("wrap count bound", 32'(max_count > DEPTH), 0);

    // Simultaneous push and pop at count 2.
    popped.delete();
    ack_next = 1'b0;
    tick();
    send_token(16'hA001);
    send_token(16'hA002);
    check("pushpop pre count", 32'(count), 2);
    check("pushpop pre head", 32'(data_out), 32'hA001);
    data_in  = 16'hA003;
    ack_next = 1'b1;
    tick();
    check("pushpop count", 32'(count), 2);
    check("pushpop data_out", 32'(data_out), 0);
    check("pushpop ack", 32'(ack), 1);
    data_in = '0;
    responder(3, 1'b0);
    for (int i = 0; i < 3; i++) check("pushpop order", 32'(popped_at(i)), 32'hA001 + i);

    // Spacer discipline and tag coverage 01/10/11.
    ack_next = 1'b1;
    tick();
    for (int t = 1; t <= 3; t++) begin
      logic [WIDTH-1:0] v;
      v = {2'(t), 14'h0111 * 14'(t)};
      send_token(v);
      repeat (3) tick();
      check("spacer hold", 32'(data_out), 0);
      ack_next = 1'b0;
      tick();
      check("spacer present", 32'(data_out), 32'(v));
      ack_next = 1'b1;
      tick();
      check("spacer pop", 32'(data_out), 0);
      check("spacer count", 32'(count), 0);
    end

    // Reset mid-operation.
    ack_next = 1'b0;
    tick();
    send_token(16'hD001);
    send_token(16'hD002);
    data_in = 16'hD003;
    tick();
    check("mid pre ack", 32'(ack), 1);
    check("mid pre count", 32'(count), 3);
    check("mid pre head", 32'(data_out), 32'hD001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst ack", 32'(ack), 0);
    check("mid rst data_out", 32'(data_out), 0);
    check("mid rst count", 32'(count), 0);
    check("mid rst empty", 32'(empty), 1);
    tick();
    check("mid reaccept ack", 32'(ack), 1);
    check("mid reaccept count", 32'(count), 1);
    data_in = '0;
    popped.delete();
    responder(1, 1'b0);
    check("mid reaccept token", 32'(popped_at(0)), 32'hD003);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
